// File: rtl/hazard_controller.sv
// Hazard and sequencing controller for the 5-stage pipeline: forwarding selects,
// load-use stall, branch flush, memory-busy freeze FSM with watchdog, and perf counters.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// ST_RUN   | pipeline flowing; freezes only if a busy input is seen now
// ST_FRZ_I | frozen on instruction-memory busy (also the post-miss settle)
// ST_FRZ_D | frozen on data-memory busy (also the post-miss settle)
module hazard_controller #(
  parameter int REG_ADDR_W   = 5,
  parameter int CNT_WIDTH    = 32,
  parameter int MISS_TIMEOUT = 1024
) (
  input  logic                  i_clk,
  input  logic                  i_arst,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
  input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
  input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
  input  logic                  i_reg_we_mem,
  input  logic                  i_reg_we_wb,
  input  logic                  i_load_instr_exec,
  input  logic                  i_pc_src_exec,
  input  logic                  i_imem_busy,
  input  logic                  i_dmem_busy,
  input  logic                  i_cnt_clear,
  output logic                  o_stall_fetch,
  output logic                  o_stall_dec,
  output logic                  o_flush_dec,
  output logic                  o_flush_exec,
  output logic                  o_freeze,
  output logic [1:0]            o_forward_rs1,
  output logic [1:0]            o_forward_rs2,
  output logic [1:0]            o_state,
  output logic                  o_timeout,
  output logic [CNT_WIDTH-1:0]  o_lu_stall_cnt,
  output logic [CNT_WIDTH-1:0]  o_flush_cnt,
  output logic [CNT_WIDTH-1:0]  o_freeze_cnt
);

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_FRZ_I = 2'd1;
  localparam logic [1:0] ST_FRZ_D = 2'd2;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [CNT_WIDTH-1:0] TIMEOUT    = CNT_WIDTH'(MISS_TIMEOUT);
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_M1 = CNT_WIDTH'(MISS_TIMEOUT - 1);

  logic [1:0]           r_state;
  logic [1:0]           w_state_nxt;
  logic                 w_frz;
  logic                 w_lu;
  logic                 w_flush_dec;
  logic [CNT_WIDTH-1:0] r_frz_run;
  logic                 r_timeout;
  logic [CNT_WIDTH-1:0] r_lu_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;
  logic [CNT_WIDTH-1:0] r_freeze_cnt;

  function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] rs);
    if (i_reg_we_mem && (i_rd_addr_mem != '0) && (i_rd_addr_mem == rs))
      return 2'b10;
    else if (i_reg_we_wb && (i_rd_addr_wb != '0) && (i_rd_addr_wb == rs))
      return 2'b01;
    else
      return 2'b00;
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (v == CNT_MAX) ? v : v + 1'b1;
  endfunction

  always_comb begin
    o_forward_rs1 = fwd_sel(i_rs1_addr_exec);
    o_forward_rs2 = fwd_sel(i_rs2_addr_exec);
  end

  assign w_lu = i_load_instr_exec && (i_rd_addr_exec != '0) &&
                ((i_rd_addr_exec == i_rs1_addr_dec) || (i_rd_addr_exec == i_rs2_addr_dec));
  assign w_frz       = (r_state != ST_RUN) || i_imem_busy || i_dmem_busy;
  assign w_flush_dec = !w_frz && i_pc_src_exec;

  // A taken branch drops the load-use stall so the redirect is accepted.
  always_comb begin
    if (i_arst) begin
      o_freeze      = 1'b0;
      o_stall_fetch = 1'b0;
      o_flush_dec   = 1'b1;
      o_flush_exec  = 1'b1;
    end else begin
      o_freeze      = w_frz;
      o_stall_fetch = w_frz || (w_lu && !i_pc_src_exec);
      o_flush_dec   = w_flush_dec;
      o_flush_exec  = !w_frz && (i_pc_src_exec || w_lu);
    end
    o_stall_dec = o_stall_fetch;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_RUN: begin
        if (i_dmem_busy)      w_state_nxt = ST_FRZ_D;
        else if (i_imem_busy) w_state_nxt = ST_FRZ_I;
      end
      ST_FRZ_D: begin
        if (!i_dmem_busy && i_imem_busy)  w_state_nxt = ST_FRZ_I;
        else if (!i_dmem_busy)            w_state_nxt = ST_RUN;
      end
      ST_FRZ_I: begin
        if (i_dmem_busy)       w_state_nxt = ST_FRZ_D;
        else if (!i_imem_busy) w_state_nxt = ST_RUN;
      end
      default: w_state_nxt = ST_RUN;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_arst) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  // frz_run saturates at the timeout so it never wraps during a long stall.
  always_ff @(posedge i_clk) begin
    if (i_arst || i_cnt_clear) begin
      r_frz_run <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (!w_frz)                   r_frz_run <= '0;
      else if (r_frz_run != TIMEOUT) r_frz_run <= r_frz_run + 1'b1;
      if (w_frz && (r_frz_run >= TIMEOUT_M1)) r_timeout <= 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_arst || i_cnt_clear) begin
      r_lu_cnt     <= '0;
      r_flush_cnt  <= '0;
      r_freeze_cnt <= '0;
    end else begin
      if (w_lu && !i_pc_src_exec && !w_frz) r_lu_cnt <= sat_inc(r_lu_cnt);
      if (w_flush_dec)                      r_flush_cnt <= sat_inc(r_flush_cnt);
      if (w_frz)                            r_freeze_cnt <= sat_inc(r_freeze_cnt);
    end
  end

  assign o_state        = r_state;
  assign o_timeout      = r_timeout;
  assign o_lu_stall_cnt = r_lu_cnt;
  assign o_flush_cnt    = r_flush_cnt;
  assign o_freeze_cnt   = r_freeze_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed bench for hazard_controller: a cycle-level reference model checked every
// cycle, plus hand-computed literal expectations for each scenario.
module tb_hazard_controller;
  localparam int RW = 5;
  localparam int CW = 4;
  localparam int MT = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic          i_clk = 1'b0;
  logic          i_arst;
  logic [RW-1:0] i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec;
  logic [RW-1:0] i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb;
  logic          i_reg_we_mem, i_reg_we_wb, i_load_instr_exec, i_pc_src_exec;
  logic          i_imem_busy, i_dmem_busy, i_cnt_clear;
  logic          o_stall_fetch, o_stall_dec, o_flush_dec, o_flush_exec, o_freeze, o_timeout;
  logic [1:0]    o_forward_rs1, o_forward_rs2, o_state;
  logic [CW-1:0] o_lu_stall_cnt, o_flush_cnt, o_freeze_cnt;

  int n_checks = 0;
  int n_pass   = 0;

  hazard_controller #(.REG_ADDR_W(RW), .CNT_WIDTH(CW), .MISS_TIMEOUT(MT)) dut (
    .i_clk(i_clk), .i_arst(i_arst),
    .i_rs1_addr_dec(i_rs1_addr_dec), .i_rs2_addr_dec(i_rs2_addr_dec),
    .i_rs1_addr_exec(i_rs1_addr_exec), .i_rs2_addr_exec(i_rs2_addr_exec),
    .i_rd_addr_exec(i_rd_addr_exec), .i_rd_addr_mem(i_rd_addr_mem), .i_rd_addr_wb(i_rd_addr_wb),
    .i_reg_we_mem(i_reg_we_mem), .i_reg_we_wb(i_reg_we_wb),
    .i_load_instr_exec(i_load_instr_exec), .i_pc_src_exec(i_pc_src_exec),
    .i_imem_busy(i_imem_busy), .i_dmem_busy(i_dmem_busy), .i_cnt_clear(i_cnt_clear),
    .o_stall_fetch(o_stall_fetch), .o_stall_dec(o_stall_dec),
    .o_flush_dec(o_flush_dec), .o_flush_exec(o_flush_exec), .o_freeze(o_freeze),
    .o_forward_rs1(o_forward_rs1), .o_forward_rs2(o_forward_rs2), .o_state(o_state),
    .o_timeout(o_timeout), .o_lu_stall_cnt(o_lu_stall_cnt),
    .o_flush_cnt(o_flush_cnt), .o_freeze_cnt(o_freeze_cnt)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: the registered freeze cause is simply last cycle's busy, dmem first.
  int m_cause = 0, m_run = 0, m_lu = 0, m_fl = 0, m_fz = 0;
  bit m_to = 0, m_valid = 0;

  function automatic bit is_lu();
    return i_load_instr_exec && i_rd_addr_exec != 0 &&
           (i_rd_addr_exec == i_rs1_addr_dec || i_rd_addr_exec == i_rs2_addr_dec);
  endfunction

  function automatic int fwd(input logic [RW-1:0] rs);
    if (i_reg_we_mem && i_rd_addr_mem != 0 && i_rd_addr_mem == rs) return 2;
    if (i_reg_we_wb && i_rd_addr_wb != 0 && i_rd_addr_wb == rs) return 1;
    return 0;
  endfunction

  always @(posedge i_clk) begin
    bit frz;
    frz = (m_cause != 0) || i_imem_busy || i_dmem_busy;
    if (i_arst) begin
      m_cause = 0; m_run = 0; m_to = 0; m_lu = 0; m_fl = 0; m_fz = 0; m_valid = 1;
    end else begin
      if (i_cnt_clear) begin
        m_run = 0; m_to = 0; m_lu = 0; m_fl = 0; m_fz = 0;
      end else begin
        if (is_lu() && !i_pc_src_exec && !frz && m_lu < CMAX) m_lu++;
        if (!frz && i_pc_src_exec && m_fl < CMAX) m_fl++;
        if (frz && m_fz < CMAX) m_fz++;
        m_run = frz ? m_run + 1 : 0;
        if (m_run >= MT) m_to = 1;
      end
      m_cause = i_dmem_busy ? 2 : (i_imem_busy ? 1 : 0);
    end
  end

  always @(negedge i_clk) begin
    if (m_valid) begin
      bit frz, lu, sf;
      frz = (m_cause != 0) || i_imem_busy || i_dmem_busy;
      lu  = is_lu();
      sf  = i_arst ? 1'b0 : (frz || (lu && !i_pc_src_exec));
      chk("m_fwd1", int'(o_forward_rs1), fwd(i_rs1_addr_exec));
      chk("m_fwd2", int'(o_forward_rs2), fwd(i_rs2_addr_exec));
      chk("m_freeze", int'(o_freeze), i_arst ? 0 : int'(frz));
      chk("m_stall_fetch", int'(o_stall_fetch), int'(sf));
      chk("m_stall_dec", int'(o_stall_dec), int'(sf));
      chk("m_flush_dec", int'(o_flush_dec), i_arst ? 1 : int'(!frz && i_pc_src_exec));
      chk("m_flush_exec", int'(o_flush_exec), i_arst ? 1 : int'(!frz && (i_pc_src_exec || lu)));
      chk("m_state", int'(o_state), m_cause);
      chk("m_timeout", int'(o_timeout), int'(m_to));
      chk("m_lu_cnt", int'(o_lu_stall_cnt), m_lu);
      chk("m_flush_cnt", int'(o_flush_cnt), m_fl);
      chk("m_freeze_cnt", int'(o_freeze_cnt), m_fz);
    end
  end

  task automatic next_cycle();
    @(posedge i_clk); #1;
  endtask

  task automatic idle_inputs();
    i_rs1_addr_dec = 0; i_rs2_addr_dec = 0; i_rs1_addr_exec = 0; i_rs2_addr_exec = 0;
    i_rd_addr_exec = 0; i_rd_addr_mem = 0; i_rd_addr_wb = 0;
    i_reg_we_mem = 0; i_reg_we_wb = 0; i_load_instr_exec = 0; i_pc_src_exec = 0;
    i_imem_busy = 0; i_dmem_busy = 0; i_cnt_clear = 0;
  endtask

  task automatic pulse_clear();
    i_cnt_clear = 1; next_cycle(); i_cnt_clear = 0;
  endtask

  initial begin
    int ovl_state [6];
    ovl_state = '{2, 2, 1, 1, 1, 0};
    idle_inputs();
    i_arst = 1;
    next_cycle(); next_cycle();
    @(negedge i_clk);
    chk("rst_flush_dec", int'(o_flush_dec), 1);
    chk("rst_flush_exec", int'(o_flush_exec), 1);
    chk("rst_stall_fetch", int'(o_stall_fetch), 0);
    chk("rst_state", int'(o_state), 0);
    chk("rst_freeze_cnt", int'(o_freeze_cnt), 0);
    next_cycle();
    i_arst = 0;
    next_cycle();

    // forwarding priority and x0
    i_rs1_addr_exec = 5; i_rs2_addr_exec = 5; i_rd_addr_mem = 5; i_rd_addr_wb = 5;
    i_reg_we_mem = 1; i_reg_we_wb = 1;
    @(negedge i_clk); chk("fwd_mem", int'(o_forward_rs1), 2);
    next_cycle(); i_reg_we_mem = 0;
    @(negedge i_clk); chk("fwd_wb", int'(o_forward_rs1), 1);
    next_cycle(); i_reg_we_mem = 1; i_rs1_addr_exec = 0; i_rd_addr_mem = 0; i_rd_addr_wb = 0;
    @(negedge i_clk); chk("fwd_x0", int'(o_forward_rs1), 0);
    next_cycle(); idle_inputs();

    // load-use, one cycle
    i_load_instr_exec = 1; i_rd_addr_exec = 7; i_rs2_addr_dec = 7;
    @(negedge i_clk);
    chk("lu_stall_fetch", int'(o_stall_fetch), 1);
    chk("lu_flush_exec", int'(o_flush_exec), 1);
    chk("lu_flush_dec", int'(o_flush_dec), 0);
    chk("lu_cnt_before", int'(o_lu_stall_cnt), 0);
    next_cycle(); idle_inputs();
    @(negedge i_clk);
    chk("lu_stall_gone", int'(o_stall_fetch), 0);
    chk("lu_cnt_after", int'(o_lu_stall_cnt), 1);
    next_cycle();

    // branch overrides load-use
    pulse_clear();
    i_load_instr_exec = 1; i_rd_addr_exec = 7; i_rs2_addr_dec = 7; i_pc_src_exec = 1;
    @(negedge i_clk);
    chk("br_stall_fetch", int'(o_stall_fetch), 0);
    chk("br_flush_dec", int'(o_flush_dec), 1);
    chk("br_flush_exec", int'(o_flush_exec), 1);
    next_cycle(); idle_inputs();
    @(negedge i_clk);
    chk("br_flush_cnt", int'(o_flush_cnt), 1);
    chk("br_lu_cnt", int'(o_lu_stall_cnt), 0);
    next_cycle();

    // data freeze with a pending branch
    pulse_clear();
    i_pc_src_exec = 1;
    for (int c = 1; c <= 5; c++) begin
      i_dmem_busy = (c <= 3);
      @(negedge i_clk);
      chk("dfrz_freeze", int'(o_freeze), (c <= 4) ? 1 : 0);
      chk("dfrz_flush_dec", int'(o_flush_dec), (c == 5) ? 1 : 0);
      if (c >= 2) chk("dfrz_state", int'(o_state), (c <= 4) ? 2 : 0);
      next_cycle();
    end
    idle_inputs();
    @(negedge i_clk); chk("dfrz_freeze_cnt", int'(o_freeze_cnt), 4);
    next_cycle();

    // overlapping busy: dmem for 2 cycles, imem for 5
    for (int c = 1; c <= 7; c++) begin
      i_dmem_busy = (c <= 2);
      i_imem_busy = (c <= 5);
      @(negedge i_clk);
      if (c >= 2) chk("ovl_state", int'(o_state), ovl_state[c-2]);
      next_cycle();
    end
    idle_inputs();
    next_cycle();

    // watchdog, saturation, clear
    pulse_clear();
    i_imem_busy = 1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge i_clk);
      chk("wd_timeout", int'(o_timeout), (c > MT) ? 1 : 0);
      next_cycle();
    end
    @(negedge i_clk); chk("wd_freeze_sat", int'(o_freeze_cnt), CMAX);
    i_imem_busy = 0;
    next_cycle(); next_cycle();
    @(negedge i_clk); chk("wd_sticky", int'(o_timeout), 1);
    pulse_clear();
    @(negedge i_clk);
    chk("clr_timeout", int'(o_timeout), 0);
    chk("clr_freeze_cnt", int'(o_freeze_cnt), 0);
    chk("clr_flush_cnt", int'(o_flush_cnt), 0);
    next_cycle();

    // reset mid-freeze
    i_imem_busy = 1; i_pc_src_exec = 1;
    next_cycle(); next_cycle(); next_cycle();
    i_arst = 1;
    @(negedge i_clk);
    chk("rstf_flush_dec", int'(o_flush_dec), 1);
    chk("rstf_flush_exec", int'(o_flush_exec), 1);
    chk("rstf_freeze", int'(o_freeze), 0);
    next_cycle();
    @(negedge i_clk); chk("rstf_state", int'(o_state), 0);
    next_cycle();
    i_arst = 0; idle_inputs();
    next_cycle(); next_cycle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL sim_timeout: got no finish, expected finish before 200000");
    $fatal(1);
  end
endmodule
